// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port; single-word reads and writes,
// round-robin or fixed-priority arbitration, configurable read latency.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned PRIO   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StWrite, StReadWait} state_e;

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                pick0;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Requester 0 wins a tie under fixed priority, or when requester 1 was granted last.
  assign pick0     = req0 && (!req1 || (PRIO != 0) || last_q);
  assign sel_we    = pick0 ? we0 : we1;
  assign sel_addr  = pick0 ? addr0 : addr1;
  assign sel_wdata = pick0 ? wdata0 : wdata1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d     = !pick0;
          last_d      = !pick0;
          gnt0_d      = pick0;
          gnt1_d      = !pick0;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          if (sel_we) begin
            state_d = StWrite;
          end else begin
            state_d = StReadWait;
            cnt_d   = 2'(RD_LAT - 1);
          end
        end
      end
      StWrite: begin
        state_d = StIdle;
      end
      StReadWait: begin
        if (cnt_q == 2'd0) begin
          if (owner_q) begin
            rdata1_d  = mem_rdata;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_rdata;
            rvalid0_d = 1'b1;
          end
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 2'd0;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three parameterisations, each with a cycle-level reference
// model feeding grant/read-data expectation queues that a separate monitor drains.
module tb_mem_arbiter;

  localparam int NumInst = 3;

  typedef struct {
    int          port;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    int          cyc;
  } gexp_t;

  typedef struct {
    int          port;
    logic [15:0] d;
    int          cyc;
  } rexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic tally(input bit ok, input string what);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s", what);
  endtask

  for (genvar g = 0; g < NumInst; g++) begin : gi
    localparam int unsigned Lat  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    localparam int unsigned Prio = (g == 2) ? 1 : 0;

    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we  = '0;
    logic [15:0] addr  [2] = '{default: '0};
    logic [15:0] wdata [2] = '{default: '0};
    logic        gnt0, gnt1, rv0, rv1, mem_we;
    logic [15:0] rd0, rd1, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] phys    [256] = '{default: '0};
    logic [15:0] ref_mem [256] = '{default: '0};
    gexp_t       eg[$];
    rexp_t       er[$];
    int          cyc = 0;
    bit          done = 1'b0;

    mem_arbiter #(
      .ADDR_W(16),
      .DATA_W(16),
      .RD_LAT(Lat),
      .PRIO  (Prio)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req[0]),
      .req1     (req[1]),
      .we0      (we[0]),
      .we1      (we[1]),
      .addr0    (addr[0]),
      .addr1    (addr[1]),
      .wdata0   (wdata[0]),
      .wdata1   (wdata[1]),
      .gnt0     (gnt0),
      .gnt1     (gnt1),
      .rvalid0  (rv0),
      .rvalid1  (rv1),
      .rdata0   (rd0),
      .rdata1   (rd1),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
    );

    // Memory: asynchronous read of the held address, write on mem_we.
    assign mem_rdata = phys[mem_addr[7:0]];
    always @(posedge clk) if (mem_we) phys[mem_addr[7:0]] <= mem_wdata;

    // Reference model: the port is free again 2 cycles after a write grant and
    // Lat+1 cycles after a read grant; any request seen while free is granted.
    initial begin : model
      int w;
      bit last;
      int free_at;
      last = 1'b1;
      free_at = 0;
      forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
          eg.delete();
          er.delete();
          free_at = 0;
          last = 1'b1;
        end else begin
          cyc++;
          if (cyc >= free_at && (req[0] || req[1])) begin
            if (req[0] && req[1]) w = (Prio != 0) ? 0 : (last ? 0 : 1);
            else w = req[1] ? 1 : 0;
            last = (w == 1);
            eg.push_back('{w, we[w], addr[w], wdata[w], cyc});
            if (we[w]) begin
              ref_mem[addr[w][7:0]] = wdata[w];
              free_at = cyc + 2;
            end else begin
              er.push_back('{w, ref_mem[addr[w][7:0]], cyc + int'(Lat)});
              free_at = cyc + int'(Lat) + 1;
            end
          end
        end
      end
    end

    initial begin : monitor
      gexp_t       e;
      rexp_t       r;
      int          p;
      logic [15:0] rd, other;
      logic [15:0] last_rd [2];
      last_rd[0] = '0;
      last_rd[1] = '0;
      forever begin
        @(negedge clk);
        if (rst) begin
          last_rd[0] = '0;
          last_rd[1] = '0;
        end else begin
          if (gnt0 && gnt1) begin
            tally(1'b0, $sformatf("inst%0d dual_grant: got gnt0=1 gnt1=1, expected one", g));
          end else if (gnt0 || gnt1) begin
            p = gnt1 ? 1 : 0;
            if (eg.size() == 0) begin
              tally(1'b0, $sformatf("inst%0d grant: got gnt%0d at cyc %0d, expected none",
                                    g, p, cyc));
            end else begin
              e = eg.pop_front();
              tally(p == e.port && cyc == e.cyc && mem_we == e.w && mem_addr == e.a &&
                    (!e.w || mem_wdata == e.d),
                    $sformatf({"inst%0d grant: got port %0d cyc %0d we %0b addr %h wdata %h,",
                               " expected port %0d cyc %0d we %0b addr %h wdata %h"},
                              g, p, cyc, mem_we, mem_addr, mem_wdata,
                              e.port, e.cyc, e.w, e.a, e.d));
            end
          end else if (mem_we) begin
            tally(1'b0, $sformatf("inst%0d mem_we: got 1 at cyc %0d, expected 0", g, cyc));
          end

          if (rv0 && rv1) begin
            tally(1'b0, $sformatf("inst%0d dual_rvalid: got both, expected at most one", g));
          end else if (rv0 || rv1) begin
            p = rv1 ? 1 : 0;
            rd = rv1 ? rd1 : rd0;
            other = rv1 ? rd0 : rd1;
            if (er.size() == 0) begin
              tally(1'b0, $sformatf("inst%0d rvalid: got rvalid%0d at cyc %0d, expected none",
                                    g, p, cyc));
            end else begin
              r = er.pop_front();
              tally(p == r.port && cyc == r.cyc && rd == r.d && other == last_rd[1-p],
                    $sformatf({"inst%0d read: got port %0d cyc %0d data %h other %h,",
                               " expected port %0d cyc %0d data %h other %h"},
                              g, p, cyc, rd, other, r.port, r.cyc, r.d, last_rd[1-p]));
              last_rd[r.port] = r.d;
            end
          end
        end
      end
    end

    task automatic txn(input int r, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int gap);
      bit got;
      got = 1'b0;
      repeat (gap) @(negedge clk);
      req[r] = 1'b1;
      we[r] = w;
      addr[r] = a;
      wdata[r] = d;
      for (int k = 0; k < 2000 && !got; k++) begin
        @(negedge clk);
        got = (r == 0) ? gnt0 : gnt1;
      end
      if (!got) tally(1'b0, $sformatf("inst%0d grant_wait: got no gnt%0d, expected one", g, r));
      req[r] = 1'b0;
    endtask

    task automatic check_zero(input string name);
      tally({gnt0, gnt1, rv0, rv1, mem_we} == 5'b0 && rd0 == 0 && rd1 == 0 &&
            mem_addr == 0 && mem_wdata == 0,
            $sformatf({"inst%0d %s: got gnt %b%b rvalid %b%b rdata %h %h we %b addr %h",
                       " wdata %h, expected all zero"},
                      g, name, gnt0, gnt1, rv0, rv1, rd0, rd1, mem_we, mem_addr, mem_wdata));
    endtask

    initial begin : driver
      bit got, saw_rv;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;

      txn(0, 1'b1, 16'h0010, 16'hBEEF, 1);
      txn(1, 1'b0, 16'h0010, 16'h0000, 1);
      txn(0, 1'b1, 16'h0001, 16'h1111, 0);
      txn(1, 1'b1, 16'h0002, 16'h2222, 0);
      fork
        begin txn(0, 1'b0, 16'h0001, 16'h0, 1); txn(0, 1'b0, 16'h0001, 16'h0, 0); end
        begin txn(1, 1'b0, 16'h0002, 16'h0, 1); txn(1, 1'b0, 16'h0002, 16'h0, 0); end
      join
      for (int i = 0; i < 6; i++) txn(0, 1'b1, 16'h0020 + 16'(i), 16'($urandom), 0);
      for (int i = 0; i < 6; i++) txn(1, 1'b0, 16'h0020 + 16'(i), 16'h0, 0);

      fork
        repeat (40) txn(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                        16'($urandom), $urandom_range(0, 3));
        repeat (40) txn(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
                        16'($urandom), $urandom_range(0, 3));
      join

      // Reset while a read is in flight: nothing may complete afterwards.
      repeat (int'(Lat) + 3) @(negedge clk);
      req[0] = 1'b1;
      we[0] = 1'b0;
      addr[0] = 16'h0005;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        got = gnt0;
      end
      tally(got, $sformatf("inst%0d reset_read_gnt: got %0b, expected 1", g, got));
      req[0] = 1'b0;
      #2 rst = 1'b1;
      #1 check_zero("reset_mid_read");
      saw_rv = 1'b0;
      repeat (3) begin
        @(negedge clk);
        saw_rv |= rv0 | rv1;
      end
      rst = 1'b0;
      repeat (int'(Lat) + 3) begin
        @(negedge clk);
        saw_rv |= rv0 | rv1;
      end
      tally(!saw_rv, $sformatf("inst%0d no_rvalid_after_reset: got %0b, expected 0", g, saw_rv));
      txn(1, 1'b0, 16'h0005, 16'h0, 0);

      repeat (int'(Lat) + 4) @(negedge clk);
      tally(eg.size() == 0, $sformatf("inst%0d grants_left: got %0d, expected 0", g, eg.size()));
      tally(er.size() == 0, $sformatf("inst%0d reads_left: got %0d, expected 0", g, er.size()));
      done = 1'b1;
    end
  end

  initial begin : top
    bit all_done;
    all_done = 1'b0;
    for (int t = 0; t < 50000 && !all_done; t++) begin
      @(negedge clk);
      all_done = gi[0].done && gi[1].done && gi[2].done;
    end
    tally(all_done, $sformatf("run_timeout: got done=%0b, expected 1", all_done));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 16-bit memory port between two requesters: requester 0 is the processor fetch/data path, requester 1 is the loader/debug path that fills program memory before and during execution. Each requester issues single-word read or write transactions over a req/gnt/rvalid handshake. The arbiter serialises them onto one memory interface (mem_we, mem_addr, mem_wdata, mem_rdata) with a configurable read latency. It sits between the processor core and the memory model in the top level.

## Interface
Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 1, memory read latency in cycles (legal range 1..4)
- PRIO, 0, 0 = round-robin, 1 = fixed priority (requester 0 always wins)

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  transaction request, held until gnt seen
- we0 / we1  in  1  1 = write, 0 = read; valid while req high
- addr0 / addr1  in  ADDR_W  transaction address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse
- rvalid0 / rvalid1  out  1  one-cycle read-data-valid pulse
- rdata0 / rdata1  out  DATA_W  read data, valid with rvalid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, WRITE, READ_WAIT.
- IDLE: sample req0/req1 each rising edge. If any request is present, pick a winner, latch its we/addr/wdata, and drive mem_addr, mem_wdata and mem_we = we. Pulse gnt of the winner. Go to WRITE if we = 1, otherwise to READ_WAIT with the latency counter loaded to RD_LAT-1. If no request is present, stay in IDLE with mem_we = 0.
- WRITE: lasts exactly one cycle with mem_we = 1. At the next edge, mem_we goes to 0 and the FSM returns to IDLE.
- READ_WAIT: mem_we = 0 and mem_addr is held. The counter decrements each edge. At the edge where the counter reaches 0, register mem_rdata into rdata of the granted requester, pulse its rvalid, and return to IDLE.
- Arbitration, round-robin: a last_grant register tracks the most recent winner. When both requesters ask, the one that was not last granted wins. last_grant resets to 1, so requester 0 wins the first tie.
- Arbitration, PRIO=1: requester 0 wins whenever req0 = 1.
- A single requester asking alone always wins, whatever last_grant holds.
- req, we, addr and wdata are ignored outside IDLE. The losing requester keeps req high and is served in a later IDLE cycle.
- The requester drops req in the cycle after it sees gnt. If req is still high at the next IDLE sample, it is treated as a new transaction.
- rdata0/rdata1 hold their last value between rvalid pulses.
- mem_addr and mem_wdata hold their last value in IDLE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, counter = 0, last_grant = 1.
- All outputs are registered; there is no combinational path from any input to any output.
- Write: request sampled at edge E0. gnt and mem_we are high during cycle E0..E0+1. The next grant is possible at E0+2.
- Read: request sampled at E0. mem_addr is valid from E0, and mem_rdata is sampled at E0+RD_LAT. rvalid is high during cycle E0+RD_LAT..E0+RD_LAT+1. The next grant is possible at E0+RD_LAT+1.
- Reset mid-transaction: the transaction is dropped, with no gnt/rvalid completion. mem_we drops to 0 asynchronously.
- Simultaneous req0 and req1 in IDLE: exactly one gnt pulses; the two grants are never high in the same cycle.

## Test plan
- Reset: assert rst mid-read (RD_LAT=2) → all outputs 0 immediately; no rvalid after release; first request after release is served normally.
- Single write: req0=1, we0=1, addr0=0x0010, wdata0=0xBEEF → gnt0 and mem_we=1 with mem_addr=0x0010, mem_wdata=0xBEEF for exactly one cycle; gnt1 stays 0.
- Single read, RD_LAT=1 and RD_LAT=3: req1 read addr 0x0010 with memory returning 0xBEEF → rvalid1 pulses 1 and 3 cycles after gnt1 respectively, rdata1=0xBEEF.
- Round-robin contention: req0 and req1 held high for reads of 0x0001 and 0x0002 → grant order 0,1,0,1; each rdata matches its own address.
- Fixed priority (PRIO=1): both requesting continuously → only gnt0 pulses; gnt1 pulses only after req0 drops.
- Back-to-back writes from one requester: req0 held high with changing wdata → a write every 2 cycles; memory contents match the sequence.
